// File: rtl/decode_skid_ctrl_pkg.sv
// Shared decode definitions for decode_skid_ctrl: opcodes, immediate-select
// codes, opcode classes, skid FSM states and the decode result record.
package rv_decode_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_U = 2'd3;

    typedef enum logic [3:0] {
        OPC_OPIMM  = 4'd0,
        OPC_OP     = 4'd1,
        OPC_LOAD   = 4'd2,
        OPC_STORE  = 4'd3,
        OPC_BRANCH = 4'd4,
        OPC_JAL    = 4'd5,
        OPC_JALR   = 4'd6,
        OPC_LUI    = 4'd7,
        OPC_AUIPC  = 4'd8,
        OPC_SYSTEM = 4'd9,
        OPC_ILL    = 4'd15
    } opc_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] imm_sel;
        opc_e       op_class;
        logic       is_jal;
        logic       illegal;
    } dec_t;

    // Decode fields of the reset/flush NOP (addi x0,x0,0).
    localparam dec_t DEC_NOP = '{imm_sel: IMM_I, op_class: OPC_OPIMM, is_jal: 1'b0, illegal: 1'b0};

endpackage

// File: rtl/decode_skid_ctrl_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// master = fetch/execute environment, slave = decode_skid_ctrl.
interface decode_skid_ctrl_if #(parameter int N = 32);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_instr;
    logic [N-1:0] in_pc;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_instr;
    logic [N-1:0] out_pc;
    logic [1:0]   imm_sel;
    logic [3:0]   op_class;
    logic         is_jal;
    logic         illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, imm_sel, op_class, is_jal, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, imm_sel, op_class, is_jal, illegal
    );
endinterface

// File: rtl/decode_skid_ctrl_classifier.sv
// Combinational opcode classifier: instr[6:0] -> imm_sel/op_class/is_jal/illegal.
// Illegal detection is present only when DECODE_ILLEGAL_EN is defined.
module opcode_classifier
    import rv_decode_pkg::*;
(
    input  logic [6:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec = DEC_NOP;
        case (opcode)
            OP_LUI:    begin dec.imm_sel = IMM_U; dec.op_class = OPC_LUI;    end
            OP_AUIPC:  begin dec.imm_sel = IMM_U; dec.op_class = OPC_AUIPC;  end
            OP_BRANCH: begin dec.imm_sel = IMM_B; dec.op_class = OPC_BRANCH; end
            OP_STORE:  begin dec.imm_sel = IMM_S; dec.op_class = OPC_STORE;  end
            OP_LOAD:   dec.op_class = OPC_LOAD;
            OP_OPIMM:  dec.op_class = OPC_OPIMM;
            OP_JALR:   dec.op_class = OPC_JALR;
            OP_SYSTEM: dec.op_class = OPC_SYSTEM;
            OP_OP:     dec.op_class = OPC_OP;
            // J-immediate is built downstream; imm_sel stays I and is ignored.
            OP_JAL:    begin dec.op_class = OPC_JAL; dec.is_jal = 1'b1; end
`ifdef DECODE_ILLEGAL_EN
            default:   begin dec.op_class = OPC_ILL; dec.illegal = 1'b1; end
`else
            default:   dec.op_class = OPC_OPIMM;
`endif
        endcase
`ifdef DECODE_ILLEGAL_EN
        // Compressed/invalid encodings are rejected whatever the opcode looks like.
        if (opcode[1:0] != 2'b11) begin
            dec = '{imm_sel: IMM_I, op_class: OPC_ILL, is_jal: 1'b0, illegal: 1'b1};
        end
`endif
    end

endmodule

// File: rtl/decode_skid_ctrl.sv
// Decode stage: classify fetched instructions and hold them in a 2-entry
// (main + skid) buffer. Optional illegal-opcode detection via DECODE_ILLEGAL_EN.
module decode_skid_ctrl
    import rv_decode_pkg::*;
#(
    parameter int           N         = 32,
    parameter logic [N-1:0] NOP_INSTR = N'(32'h0000_0013)
) (
    input logic              clk,
    input logic              rst_n,
    input logic              flush,
    decode_skid_ctrl_if.slave bus
);

    typedef struct packed {
        logic [N-1:0] instr;
        logic [N-1:0] pc;
        dec_t         dec;
    } ent_t;

    localparam ent_t RST_ENT = '{instr: NOP_INSTR, pc: '0, dec: DEC_NOP};

    state_e state;
    ent_t   main_q;
    ent_t   skid_q;
    ent_t   in_ent;
    dec_t   in_dec;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   retire;

    opcode_classifier u_cls (
        .opcode (bus.in_instr[6:0]),
        .dec    (in_dec)
    );

    assign in_ent = '{instr: bus.in_instr, pc: bus.in_pc, dec: in_dec};
    assign accept = bus.in_valid & in_ready_q;
    assign retire = out_valid_q & bus.out_ready;

    // in_ready/out_valid are registered copies of (next_state != TWO/EMPTY).
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state       <= ST_EMPTY;
            main_q      <= RST_ENT;
            skid_q      <= RST_ENT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q      <= in_ent;
                        state       <= ST_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !retire) begin
                        skid_q     <= in_ent;
                        state      <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (accept && retire) begin
                        main_q <= in_ent;
                    end else if (retire) begin
                        state       <= ST_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_TWO: begin
                    // The skid entry is always older than anything fetched later.
                    if (retire) begin
                        main_q     <= skid_q;
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = main_q.instr;
    assign bus.out_pc    = main_q.pc;
    assign bus.imm_sel   = main_q.dec.imm_sel;
    assign bus.op_class  = main_q.dec.op_class;
    assign bus.is_jal    = main_q.dec.is_jal;
    assign bus.illegal   = main_q.dec.illegal;

endmodule
